// File: rtl/systolic_pkg.sv
// Shared sizing, state encoding and step constants for the systolic array sequencer.
package systolic_pkg;

  localparam int DIMENSION = 4;
  localparam int IDX_BITS  = $clog2(DIMENSION);
  localparam int DIAG_BITS = $clog2(2 * DIMENSION - 1);
  localparam int STEP_BITS = $clog2(3 * DIMENSION);

  // First step on which an anti-diagonal holds a finished result, and the final step.
  localparam int CAP_FIRST = DIMENSION + 1;
  localparam int LAST_STEP = 3 * DIMENSION - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/systolic_lane_sched.sv
// Per-lane skew decode: maps the global step to this lane's clear pulse and operand index.
module systolic_lane_sched
  import systolic_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic                 i_run,
  input  logic [STEP_BITS-1:0] i_step,
  output logic                 o_reset,
  output logic                 o_en,
  output logic [IDX_BITS-1:0]  o_k
);

  localparam logic [STEP_BITS-1:0] RST_STEP = STEP_BITS'(LANE);
  localparam logic [STEP_BITS-1:0] FIRST    = STEP_BITS'(LANE + 1);
  localparam logic [STEP_BITS-1:0] LAST     = STEP_BITS'(LANE + DIMENSION);

  always_comb begin
    o_reset = i_run && (i_step == RST_STEP);
    o_en    = i_run && (i_step >= FIRST) && (i_step <= LAST);
    // k = step-1-lane; only the low index bits matter, so modular subtraction is exact.
    o_k     = o_en ? (i_step[IDX_BITS-1:0] - IDX_BITS'(LANE + 1)) : '0;
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a DIMENSION x DIMENSION systolic array: skewed clears, operand fetch,
// array-wide advance/stall and anti-diagonal result capture.
module systolic_seq_ctrl
  import systolic_pkg::*;
(
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic                          i_data_ready,
  input  logic                          i_cap_ready,
  output logic                          o_valid,
  output logic [DIMENSION-1:0]          o_a_reset,
  output logic [DIMENSION-1:0]          o_b_reset,
  output logic [DIMENSION-1:0]          o_lane_en,
  output logic [DIMENSION*IDX_BITS-1:0] o_k_idx,
  output logic                          o_cap_en,
  output logic [DIAG_BITS-1:0]          o_cap_diag,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam logic [STEP_BITS-1:0] CAP_FIRST_S = STEP_BITS'(CAP_FIRST);
  localparam logic [STEP_BITS-1:0] LAST_S      = STEP_BITS'(LAST_STEP);

  state_e               state_q, state_d;
  logic [STEP_BITS-1:0] s_q, s_d;
  logic                 run;
  logic                 cap_step;
  logic                 adv;

  always_comb begin
    run      = (state_q == ST_RUN);
    cap_step = run && (s_q >= CAP_FIRST_S) && (s_q <= LAST_S);
    // A capture step may only advance if the sink takes the diagonal; otherwise it would be overwritten.
    adv      = run && i_data_ready && (i_cap_ready || !cap_step);

    state_d = state_q;
    s_d     = s_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RUN;
          s_d     = '0;
        end
      end
      ST_RUN: begin
        if (adv) begin
          if (s_q == LAST_S) begin
            state_d = ST_DONE;
            s_d     = '0;
          end else begin
            s_d = s_q + STEP_BITS'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
    end
  end

  assign o_valid    = adv;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = (state_q == ST_DONE);
  assign o_cap_en   = cap_step;
  assign o_cap_diag = cap_step ? (s_q[DIAG_BITS-1:0] - DIAG_BITS'(CAP_FIRST)) : '0;

  // A-row and B-column lanes share the same skew, so one decoder drives both reset lanes.
  for (genvar i = 0; i < DIMENSION; i++) begin : g_lane
    logic lane_rst;
    systolic_lane_sched #(.LANE(i)) u_lane (
      .i_run   (run),
      .i_step  (s_q),
      .o_reset (lane_rst),
      .o_en    (o_lane_en[i]),
      .o_k     (o_k_idx[i*IDX_BITS +: IDX_BITS])
    );
    assign o_a_reset[i] = lane_rst;
    assign o_b_reset[i] = lane_rst;
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl at DIMENSION=4 with hand-tabulated per-step outputs.
module tb_systolic_seq_ctrl;
  import systolic_pkg::*;

  logic                          i_clock = 1'b0;
  logic                          i_reset = 1'b0;
  logic                          i_start = 1'b0;
  logic                          i_data_ready = 1'b1;
  logic                          i_cap_ready = 1'b1;
  logic                          o_valid;
  logic [DIMENSION-1:0]          o_a_reset;
  logic [DIMENSION-1:0]          o_b_reset;
  logic [DIMENSION-1:0]          o_lane_en;
  logic [DIMENSION*IDX_BITS-1:0] o_k_idx;
  logic                          o_cap_en;
  logic [DIAG_BITS-1:0]          o_cap_diag;
  logic                          o_busy;
  logic                          o_done;

  int n_chk  = 0;
  int n_pass = 0;

  systolic_seq_ctrl dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_data_ready (i_data_ready),
    .i_cap_ready  (i_cap_ready),
    .o_valid      (o_valid),
    .o_a_reset    (o_a_reset),
    .o_b_reset    (o_b_reset),
    .o_lane_en    (o_lane_en),
    .o_k_idx      (o_k_idx),
    .o_cap_en     (o_cap_en),
    .o_cap_diag   (o_cap_diag),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge i_clock);
    #1;
  endtask

  // Hand-tabulated expectations for DIMENSION=4.
  function automatic logic [3:0] exp_rst(input int s);
    case (s)
      0: return 4'b0001;
      1: return 4'b0010;
      2: return 4'b0100;
      3: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] exp_en(input int s);
    case (s)
      1: return 4'b0001;
      2: return 4'b0011;
      3: return 4'b0111;
      4: return 4'b1111;
      5: return 4'b1110;
      6: return 4'b1100;
      7: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [7:0] exp_k(input int s);
    case (s)
      2: return 8'h01;
      3: return 8'h06;
      4: return 8'h1B;
      5: return 8'h6C;
      6: return 8'hB0;
      7: return 8'hC0;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check_step(input int s, input bit adv);
    chk($sformatf("valid s%0d", s), o_valid, adv);
    chk($sformatf("a_reset s%0d", s), o_a_reset, exp_rst(s));
    chk($sformatf("b_reset s%0d", s), o_b_reset, exp_rst(s));
    chk($sformatf("lane_en s%0d", s), o_lane_en, exp_en(s));
    chk($sformatf("k_idx s%0d", s), o_k_idx, exp_k(s));
    chk($sformatf("cap_en s%0d", s), o_cap_en, (s >= 5) ? 1 : 0);
    chk($sformatf("cap_diag s%0d", s), o_cap_diag, (s >= 5) ? s - 5 : 0);
    chk($sformatf("busy s%0d", s), o_busy, 1);
    chk($sformatf("done s%0d", s), o_done, 0);
  endtask

  task automatic check_quiet(input string tag, input bit busy, input bit done);
    chk({tag, " valid"}, o_valid, 0);
    chk({tag, " a_reset"}, o_a_reset, 0);
    chk({tag, " b_reset"}, o_b_reset, 0);
    chk({tag, " lane_en"}, o_lane_en, 0);
    chk({tag, " k_idx"}, o_k_idx, 0);
    chk({tag, " cap_en"}, o_cap_en, 0);
    chk({tag, " cap_diag"}, o_cap_diag, 0);
    chk({tag, " busy"}, o_busy, busy);
    chk({tag, " done"}, o_done, done);
  endtask

  // One product. Optional data/cap stalls at a given step, start glitches at s=4 and in DONE,
  // and a mid-run reset at abort_at (-1 = none). exp_cycles = edges from start sample to DONE.
  task automatic run_seq(input int ds_at, input int ds_n, input int cs_at, input int cs_n,
                         input bit glitch, input int abort_at, input int exp_cycles);
    int  s = 0;
    int  n = 0;
    int  dn = ds_n;
    int  cn = cs_n;
    bit  adv;
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    while (s < 12 && n < 60) begin
      i_data_ready = 1'b1;
      i_cap_ready  = 1'b1;
      if (s == ds_at && dn > 0) begin i_data_ready = 1'b0; dn--; end
      if (s == cs_at && cn > 0) begin i_cap_ready  = 1'b0; cn--; end
      i_start = glitch && (s == 4);
      if (s == abort_at) i_reset = 1'b0;
      #1;
      adv = i_data_ready && (i_cap_ready || (s < 5));
      check_step(s, adv);
      if (s == abort_at) begin
        cyc();
        i_start = 1'b0;
        #1;
        check_quiet("abort", 0, 0);
        cyc();
        check_quiet("abort hold", 0, 0);
        i_reset = 1'b1;
        return;
      end
      cyc();
      n++;
      i_start = 1'b0;
      if (adv) s++;
    end
    if (n >= 60) chk("step budget", n, exp_cycles);
    i_data_ready = 1'b1;
    i_cap_ready  = 1'b1;
    i_start      = glitch;
    #1;
    check_quiet("done cycle", 1, 1);
    chk("latency", n + 1, exp_cycles);
    cyc();
    i_start = 1'b0;
    #1;
    check_quiet("post done", 0, 0);
    cyc();
    check_quiet("idle", 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    i_reset = 1'b0;
    cyc();
    cyc();
    check_quiet("reset", 0, 0);
    i_reset = 1'b1;
    cyc();
    check_quiet("idle after reset", 0, 0);

    // Ready held high: 12 advancing steps, DONE 13 edges after start.
    run_seq(-1, 0, -1, 0, 1'b0, -1, 13);
    // Data source stalls 3 cycles at s=6.
    run_seq(6, 3, -1, 0, 1'b0, -1, 16);
    // Capture sink stalls 2 cycles at s=5 (diag 0 held).
    run_seq(-1, 0, 5, 2, 1'b0, -1, 15);
    // Capture not ready on a non-capture step: no stall.
    run_seq(-1, 0, 3, 2, 1'b0, -1, 13);
    // Start pulses while busy and in DONE are ignored.
    run_seq(-1, 0, -1, 0, 1'b1, -1, 13);
    // Reset at s=7 abandons the product; a fresh start replays from s=0.
    run_seq(-1, 0, -1, 0, 1'b0, 7, 13);
    run_seq(-1, 0, -1, 0, 1'b0, -1, 13);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for a DIMENSION x DIMENSION systolic array of PE_VCounter-style processing elements.
- Per matrix product it:
  - injects skewed per-lane clear pulses on the reset lanes;
  - schedules skewed operand fetch per A-row and B-column lane;
  - drives the array-wide i_valid, stalling the whole array when the operand source or result sink is not ready;
  - tells the result-capture buffer which anti-diagonal of PEs holds a finished o_c each step.
- Sits between the operand buffers/capture FIFO and the array edge.

Parameters:
- DIMENSION, 4, array side length; number of A and B lanes.
- IDX_BITS, $clog2(DIMENSION), width of one lane operand index.
- DIAG_BITS, $clog2(2*DIMENSION-1), width of the anti-diagonal index.
- STEP_BITS, $clog2(3*DIMENSION), width of the step counter.

Ports:
- i_clock  in  1  clock; all logic on posedge.
- i_reset  in  1  synchronous reset, active-low.
- i_start  in  1  start one product; sampled only in IDLE.
- i_data_ready  in  1  operand buffers can supply this step's operands.
- i_cap_ready  in  1  capture buffer can accept a diagonal this step.
- o_valid  out  1  drives array i_valid; high exactly on steps that advance.
- o_a_reset  out  DIMENSION  per-row reset lane into column-0 PEs.
- o_b_reset  out  DIMENSION  per-column reset lane into row-0 PEs.
- o_lane_en  out  DIMENSION  lane i operand valid; when low the wrapper drives 0 into lane i.
- o_k_idx  out  DIMENSION*IDX_BITS  lane i operand index k (A[i][k], B[k][i]), packed lane 0 at LSBs.
- o_cap_en  out  1  the diagonal selected by o_cap_diag carries finished results this step.
- o_cap_diag  out  DIAG_BITS  anti-diagonal index d = row + col.
- o_busy  out  1  FSM not IDLE.
- o_done  out  1  one-cycle pulse after the final capture step.

Behaviour:
- Reset (i_reset==0 at posedge): FSM→IDLE, step counter s=0. All outputs 0 in the same cycle, then held at 0 while reset is low. Applies mid-operation too: the in-flight product is abandoned; the next i_start re-clears the array.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on i_start; s=0.
  - RUN: on each advancing step, s<=s+1. When s==3*DIMENSION-1 advances, go to DONE.
  - DONE: o_done=1 for one cycle, then IDLE.
- i_start while o_busy is ignored. i_start in the DONE cycle is ignored.
- Advance condition in RUN: adv = i_data_ready & (i_cap_ready | ~cap_step).
  - cap_step = s in [DIMENSION+1, 3*DIMENSION-1].
  - o_valid = adv, combinational from state and the ready inputs.
  - When adv=0, s holds, o_valid=0, and every other RUN output holds its current value. The PEs freeze, so the diagonal's o_c remains valid during the stall.
- Per-step outputs in RUN, all combinational from s:
  - o_a_reset[i] = o_b_reset[i] = (s==i). Skew matches the one-hop-per-step reset propagation inside the array.
  - Lane i: k = s-1-i. o_lane_en[i] = (0<=k<DIMENSION). o_k_idx lane i = k when enabled, else 0.
  - o_cap_en = cap_step. o_cap_diag = s-DIMENSION-1.
  - Diagonal d is cleared at step d, accumulates on steps d+1..d+DIMENSION, and is read on step d+DIMENSION+1. That is the only step before the PE overwrites its accumulator.
- Total advancing steps per product: 3*DIMENSION. Minimum latency from i_start to o_done is 3*DIMENSION+1 cycles.
- s never wraps. There is no overlap of products.

Decomposition:
- Shared package systolic_pkg holds:
  - DIMENSION;
  - derived widths IDX_BITS, DIAG_BITS, STEP_BITS;
  - FSM state encoding (IDLE=0, RUN=1, DONE=2);
  - helper constant CAP_FIRST = DIMENSION+1.
- One sub-module, systolic_lane_sched (combinational): instantiated per lane, mapping (s, lane) → reset, enable, k.
- The FSM and counter stay in the top module.

Test Plan:
- DIMENSION=4, ready inputs held high, i_start pulse:
  - o_valid high for 12 consecutive cycles;
  - o_a_reset[0..3] one-hot at s=0..3;
  - lane 3 enabled s=4..7 with k=0..3;
  - o_cap_en s=5..11 with o_cap_diag 0..6;
  - o_done at cycle 13.
- Drop i_data_ready for 3 cycles at s=6: o_valid=0 for exactly those cycles, all outputs frozen, s resumes at 6, o_done delayed by 3.
- Drop i_cap_ready at s=5:
  - stall with o_cap_en=1, o_cap_diag=0 held;
  - drop i_cap_ready at s=3 (non-capture step) instead: no stall.
- Pulse i_start at s=4 and in the DONE cycle: ignored, exactly one o_done.
- Assert i_reset=0 at s=7: next cycle all outputs 0, o_busy=0. A fresh i_start replays the full 12-step sequence from s=0.
- Full-array integration with the PE array, A=identity, B=[1..16]/16 in Q1.7: captured diagonals reassemble to B within 1 LSB.
